// File: rtl/stack_pkg.sv
// Shared encodings for the two-requester stack arbiter.
package stack_pkg;

    // Requester index; also the encoding of the round-robin pointer
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

    // Requested stack operation
    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_e;

    // The requester that gets priority after r has been served
    function automatic req_idx_e other_req(input req_idx_e r);
        return (r == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to the pointer.
module rr_arb2
    import stack_pkg::*;
(
    input  logic     i_req0,
    input  logic     i_req1,
    input  req_idx_e i_ptr,
    output logic     o_gnt0_c,
    output logic     o_gnt1_c
);

    // Pick at most one requester
    always_comb begin
        o_gnt0_c = 1'b0;
        o_gnt1_c = 1'b0;
        if (i_req0 && i_req1) begin
            if (i_ptr == REQ0) o_gnt0_c = 1'b1;
            else               o_gnt1_c = 1'b1;
        end else begin
            o_gnt0_c = i_req0;
            o_gnt1_c = i_req1;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto a single external stack, tracks occupancy,
// flags illegal ops and returns pop data one cycle after the pop grant.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req0,
    input  logic                             req1,
    input  logic                             op0,
    input  logic                             op1,
    input  logic [WIDTH-1:0]                 wdata0,
    input  logic [WIDTH-1:0]                 wdata1,
    output logic                             gnt0,
    output logic                             gnt1,
    output logic                             err0,
    output logic                             err1,
    output logic                             rvalid0,
    output logic                             rvalid1,
    output logic [WIDTH-1:0]                 rdata,
    output logic                             stk_push,
    output logic                             stk_pop,
    output logic [WIDTH-1:0]                 stk_d,
    input  logic [WIDTH-1:0]                 stk_q,
    output logic                             stk_reset,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_count;
    req_idx_e      r_ptr;
    logic          r_rvalid0;
    logic          r_rvalid1;

    logic          w_arb_gnt0;
    logic          w_arb_gnt1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any_gnt;
    op_e           w_op;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_illegal;

    rr_arb2 u_rr_arb2 (
        .i_req0   (req0),
        .i_req1   (req1),
        .i_ptr    (r_ptr),
        .o_gnt0_c (w_arb_gnt0),
        .o_gnt1_c (w_arb_gnt1)
    );

    // Grants are suppressed while reset is held low
    assign w_gnt0    = w_arb_gnt0 & reset;
    assign w_gnt1    = w_arb_gnt1 & reset;
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign w_op      = w_gnt1 ? op_e'(op1) : op_e'(op0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == CW'(0));

    // Legality of the granted op; push and pop are mutually exclusive by construction
    assign w_push_ok = w_any_gnt && (w_op == OP_PUSH) && !w_full;
    assign w_pop_ok  = w_any_gnt && (w_op == OP_POP)  && !w_empty;
    assign w_illegal = w_any_gnt && !w_push_ok && !w_pop_ok;

    // Occupancy, round-robin pointer and pop-return tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= CW'(0);
            r_ptr     <= REQ0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            if (w_push_ok)     r_count <= r_count + CW'(1);
            else if (w_pop_ok) r_count <= r_count - CW'(1);

            if (w_gnt0)      r_ptr <= other_req(REQ0);
            else if (w_gnt1) r_ptr <= other_req(REQ1);

            r_rvalid0 <= w_pop_ok & w_gnt0;
            r_rvalid1 <= w_pop_ok & w_gnt1;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign err0      = w_illegal & w_gnt0;
    assign err1      = w_illegal & w_gnt1;
    assign stk_push  = w_push_ok;
    assign stk_pop   = w_pop_ok;
    assign stk_d     = w_gnt1 ? wdata1 : wdata0;
    assign stk_reset = ~reset;

    // A pop return pending across an asserted reset is dropped
    assign rvalid0   = r_rvalid0 & reset;
    assign rvalid1   = r_rvalid1 & reset;
    assign rdata     = stk_q;

    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule
